// File: rtl/pulse_score_pkg.sv
// Shared defaults and elaboration helpers for the pulse-to-score chain.
// No ports; imported by pulse_score_counter.
package pulse_score_pkg;

  localparam int unsigned DefModM = 24;
  localparam int unsigned DefModN = 5;
  localparam int unsigned DefMaxM = 7;
  localparam int unsigned DefMaxN = 3;

  // True when an unsigned field of 'width' bits can hold 'max_value'.
  function automatic bit fits_width(input int unsigned width, input int unsigned max_value);
    if (width >= 32) begin
      return 1'b1;
    end
    return max_value < (32'd1 << width);
  endfunction

endpackage

// File: rtl/rise_pulse.sv
// Rising-edge detector for a level that is already synchronous to clock.
// Ports:
//   clock  - system clock
//   reset  - asynchronous active-low reset, clears edge history
//   clear  - synchronous clear of edge history (active-high)
//   sinal  - raw level input
//   pulso  - high in the first cycle sinal is seen high after it was low
// History clears to 0, so a level that is high when reset releases or
// after a clear produces one pulse.
module rise_pulse (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic sinal,
  output logic pulso
);

  logic sinal_q;
  logic sinal_d;

  always_comb begin
    sinal_d = clear ? 1'b0 : sinal;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinal_q <= 1'b0;
    end else begin
      sinal_q <= sinal_d;
    end
  end

  always_comb begin
    pulso = sinal & ~sinal_q;
  end

endmodule

// File: rtl/pulse_score_counter.sv
// Rising edges of sinal -> modulo-MOD_M event counter -> saturating score.
// Ports:
//   clock, reset (async active-low), zera_s (sync clear), conta (count enable)
//   sinal     - raw level input
//   pulso     - one-cycle rising-edge pulse
//   q_mod     - event counter, 0..MOD_M-1
//   fim_mod   - q_mod == MOD_M-1
//   meio_mod  - q_mod == MOD_M/2-1
//   tick      - one-cycle pulse on event counter wrap
//   q_max     - score, saturates at MAX_M
//   fim_max   - q_max == MAX_M
module pulse_score_counter
  import pulse_score_pkg::*;
#(
  parameter int unsigned MOD_M = DefModM,
  parameter int unsigned MOD_N = DefModN,
  parameter int unsigned MAX_M = DefMaxM,
  parameter int unsigned MAX_N = DefMaxN
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             zera_s,
  input  logic             conta,
  input  logic             sinal,
  output logic             pulso,
  output logic [MOD_N-1:0] q_mod,
  output logic             fim_mod,
  output logic             meio_mod,
  output logic             tick,
  output logic [MAX_N-1:0] q_max,
  output logic             fim_max
);

  if (MOD_M < 2 || !fits_width(MOD_N, MOD_M - 1)) begin : gen_bad_mod
    $error("pulse_score_counter: MOD_M must be >= 2 and fit in MOD_N bits");
  end
  if (!fits_width(MAX_N, MAX_M)) begin : gen_bad_max
    $error("pulse_score_counter: MAX_M must fit in MAX_N bits");
  end

  localparam logic [MOD_N-1:0] ModLast = MOD_N'(MOD_M - 1);
  localparam logic [MOD_N-1:0] ModHalf = MOD_N'(MOD_M / 2 - 1);
  localparam logic [MAX_N-1:0] MaxTop  = MAX_N'(MAX_M);

  logic             pulse_raw;
  logic             ev;
  logic             tick_raw;
  logic [MOD_N-1:0] q_mod_q, q_mod_d;
  logic [MAX_N-1:0] q_max_q, q_max_d;

  rise_pulse u_rise_pulse (
    .clock (clock),
    .reset (reset),
    .clear (zera_s),
    .sinal (sinal),
    .pulso (pulse_raw)
  );

  // Counters use the ungated pulse: while reset is low their flops are held
  // cleared anyway, so reset only needs to mask the visible outputs.
  always_comb begin
    ev       = conta & pulse_raw;
    tick_raw = ev & (q_mod_q == ModLast);
  end

  always_comb begin
    q_mod_d = q_mod_q;
    q_max_d = q_max_q;
    if (zera_s) begin
      q_mod_d = '0;
      q_max_d = '0;
    end else if (ev) begin
      q_mod_d = (q_mod_q == ModLast) ? '0 : q_mod_q + MOD_N'(1);
      if (tick_raw && (q_max_q < MaxTop)) begin
        q_max_d = q_max_q + MAX_N'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_mod_q <= '0;
      q_max_q <= '0;
    end else begin
      q_mod_q <= q_mod_d;
      q_max_q <= q_max_d;
    end
  end

  always_comb begin
    pulso    = pulse_raw & reset;
    tick     = tick_raw & reset;
    q_mod    = q_mod_q;
    fim_mod  = (q_mod_q == ModLast);
    meio_mod = (q_mod_q == ModHalf);
    q_max    = q_max_q;
    fim_max  = (q_max_q == MaxTop);
  end

endmodule

// File: tb/tb_pulse_score_counter.sv
module tb_pulse_score_counter;

  localparam int unsigned MOD_M = 24;
  localparam int unsigned MOD_N = 5;
  localparam int unsigned MAX_M = 7;
  localparam int unsigned MAX_N = 3;

  logic             clock;
  logic             reset;
  logic             zera_s;
  logic             conta;
  logic             sinal;
  logic             pulso;
  logic [MOD_N-1:0] q_mod;
  logic             fim_mod;
  logic             meio_mod;
  logic             tick;
  logic [MAX_N-1:0] q_max;
  logic             fim_max;

  pulse_score_counter #(
    .MOD_M (MOD_M),
    .MOD_N (MOD_N),
    .MAX_M (MAX_M),
    .MAX_N (MAX_N)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .zera_s   (zera_s),
    .conta    (conta),
    .sinal    (sinal),
    .pulso    (pulso),
    .q_mod    (q_mod),
    .fim_mod  (fim_mod),
    .meio_mod (meio_mod),
    .tick     (tick),
    .q_max    (q_max),
    .fim_max  (fim_max)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_seen = 0;

  // Reference model: total counted events since the last clear, and the
  // last level of sinal seen at a clock edge.
  int unsigned events = 0;
  bit          prev   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned exp_q_mod();
    return events % MOD_M;
  endfunction

  function automatic int unsigned exp_q_max();
    int unsigned wraps;
    wraps = events / MOD_M;
    return (wraps > MAX_M) ? MAX_M : wraps;
  endfunction

  task automatic check_outputs();
    bit p, e;
    p = reset && sinal && !prev;
    e = p && conta;
    check_eq("pulso", pulso, p);
    check_eq("q_mod", q_mod, exp_q_mod());
    check_eq("fim_mod", fim_mod, exp_q_mod() == MOD_M - 1);
    check_eq("meio_mod", meio_mod, exp_q_mod() == MOD_M / 2 - 1);
    check_eq("tick", tick, e && (exp_q_mod() == MOD_M - 1));
    check_eq("q_max", q_max, exp_q_max());
    check_eq("fim_max", fim_max, exp_q_max() == MAX_M);
  endtask

  // Drive one cycle at the falling edge, check mid-cycle, advance the model
  // at the rising edge.
  task automatic step(input bit s, input bit c, input bit z, input bit r);
    @(negedge clock);
    sinal = s; conta = c; zera_s = z; reset = r;
    #1;
    check_outputs();
    if (tick === 1'b1) tick_seen++;
    @(posedge clock);
    if (r) begin
      if (z) begin
        events = 0;
        prev   = 1'b0;
      end else begin
        if (c && s && !prev) events++;
        prev = s;
      end
    end
  endtask

  task automatic edges(input int n, input bit c);
    for (int i = 0; i < n; i++) begin
      step(1'b1, c, 1'b0, 1'b1);
      step(1'b0, c, 1'b0, 1'b1);
    end
  endtask

  task automatic clear_all();
    step(1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    reset = 1'b0; sinal = 1'b1; conta = 1'b1; zera_s = 1'b0;

    // Held in reset with sinal high: everything cleared, no pulse.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);

    // Release with sinal held high: one pulse, then nothing for 10 cycles.
    for (int i = 0; i < 11; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    check_eq("hold_q_mod", q_mod, 1);

    // Wrap after 24 isolated edges, then saturation after 192 total.
    clear_all();
    edges(24, 1'b1);
    #1;
    check_eq("wrap_q_mod", q_mod, 0);
    check_eq("wrap_q_max", q_max, 1);
    edges(168, 1'b1);
    #1;
    check_eq("sat_q_max", q_max, MAX_M);
    check_eq("sat_fim_max", fim_max, 1);
    edges(30, 1'b1);
    #1;
    check_eq("sat_hold_q_max", q_max, MAX_M);

    // Enable gating.
    clear_all();
    edges(5, 1'b1);
    edges(10, 1'b0);
    #1;
    check_eq("gate_q_mod", q_mod, 5);
    edges(1, 1'b1);
    #1;
    check_eq("gate_q_mod_inc", q_mod, 6);

    // Back-to-back rises: 24 rises in 48 cycles.
    clear_all();
    tick_seen = 0;
    for (int i = 0; i < 48; i++) step((i % 2) == 0, 1'b1, 1'b0, 1'b1);
    #1;
    check_eq("b2b_ticks", tick_seen, 1);
    check_eq("b2b_q_max", q_max, 1);
    check_eq("b2b_q_mod", q_mod, 0);

    // Synchronous clear coincident with a wrapping edge.
    clear_all();
    edges(23, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    check_eq("zera_q_mod", q_mod, 0);
    check_eq("zera_q_max", q_max, 0);

    // Asynchronous reset mid-count takes effect before the next clock edge.
    step(1'b0, 1'b1, 1'b0, 1'b1);
    edges(4 * MOD_M + 13, 1'b1);
    #1;
    check_eq("pre_rst_q_mod", q_mod, 13);
    check_eq("pre_rst_q_max", q_max, 4);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_q_mod", q_mod, 0);
    check_eq("async_q_max", q_max, 0);
    events = 0;
    prev   = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 127) == 0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_score_counter.md
Name: pulse_score_counter

Overview:
- Counts rising edges of a raw level input and converts them into a saturating score.
- Chain: rising-edge detector, then modulo-M event counter, then saturating score counter that advances once per modulo wrap.
- Used by game datapaths to turn button presses or map-move pulses into placement ticks and a 0..7 score.

Parameters:
- MOD_M, 24: modulus of event counter; counts 0..MOD_M-1 (MOD_M >= 2).
- MOD_N, 5: width of event counter; must satisfy 2^MOD_N >= MOD_M.
- MAX_M, 7: saturation value of score counter.
- MAX_N, 3: width of score counter; must satisfy 2^MAX_N > MAX_M.

Ports:
- clock  in  1  single system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- zera_s  in  1  synchronous clear, active-high; clears both counters and edge history on the next clock edge.
- conta  in  1  count enable; edges are ignored while 0.
- sinal  in  1  raw level input; assumed already synchronous to clock.
- pulso  out  1  one-cycle pulse on a rising edge of sinal.
- q_mod  out  MOD_N  event counter value.
- fim_mod  out  1  high while q_mod == MOD_M-1 (level).
- meio_mod  out  1  high while q_mod == MOD_M/2-1 (integer division; level).
- tick  out  1  one-cycle pulse when the event counter wraps.
- q_max  out  MAX_N  score value.
- fim_max  out  1  high while q_max == MAX_M (level).

Behaviour:
- Reset (reset=0, asynchronous): edge history=0, q_mod=0, q_max=0. Outputs during reset: pulso=0, tick=0, fim_mod=0, meio_mod=(MOD_M/2-1==0), fim_max=0.
- Edge detector:
  - registers sinal_d each cycle.
  - pulso = sinal & ~sinal_d (combinational), so it is high for exactly the first cycle sinal is 1.
  - Because history clears to 0, a sinal already high when reset is released produces one pulse.
  - Holding sinal high produces no further pulses.
- Event counter:
  - increments on each edge where ev = conta & pulso.
  - Wraps from MOD_M-1 to 0.
  - With ev=0 it holds.
- Tick: tick = ev & (q_mod == MOD_M-1), combinational. The wrap cycle is the only cycle it is high.
- Score counter:
  - increments on a clock edge when tick=1 and q_max < MAX_M.
  - At MAX_M it holds; it never wraps.
- Latency: a sinal rise at cycle t gives pulso in cycle t. q_mod updates at the edge closing cycle t; q_max updates at the same edge as the wrapping q_mod.
- Priority per clock edge:
  - reset (asynchronous) first, then zera_s, then counting.
  - zera_s=1 clears q_mod, q_max and sinal_d regardless of ev or tick.
- Events arriving one per cycle (sinal toggling every cycle with conta=1) are all counted; there is no missed-edge condition.
- Widths: all compares are unsigned at the declared widths; there is no overflow beyond the stated wrap and saturation rules.

Decomposition:
- Package (pulse_score_pkg): default constants MOD_M/MOD_N/MAX_M/MAX_N and a helper clog2-style width check, used by elaboration assertions.
- One natural sub-module: rise_pulse (edge detector: clock, reset, clear, sinal, pulso).
- Both counters stay inline in pulse_score_counter.

Test Plan:
- Reset/idle: assert reset=0 with sinal=1, then release with sinal=1 held -> pulso=1 for exactly 1 cycle, q_mod=1; holding sinal for 10 cycles leaves q_mod=1 with no further pulses.
- Wrap: MOD_M=24, conta=1, 24 isolated rising edges -> q_mod runs 0..23; fim_mod high at 23, meio_mod high at 11; the 24th edge gives tick=1 for one cycle, q_mod=0, q_max=1.
- Saturation: 8*24=192 edges -> q_max sequence 1..7; fim_max=1 from 7 onward; q_max stays 7 after the 8th wrap (no wrap to 0).
- Enable gating: conta=0 while sinal toggles 10 times -> q_mod, q_max unchanged; then conta=1 and one edge -> q_mod +1.
- Back-to-back edges: sinal toggling every cycle for 48 cycles (24 rises) -> exactly one tick, q_max=1.
- Clears: zera_s=1 coincident with a wrapping edge -> q_mod=0 and q_max=0 next cycle. Asynchronous reset mid-count (q_mod=13, q_max=4) -> both 0 immediately, before the next clock edge.
